// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dac_pkg
//  Purpose  : Shared types and constants for the multi-channel serial DAC
//             driver: FSM state encoding, default parameter values and the
//             channel-index width helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package dac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } dac_state_e;

   localparam int DEF_NUM_CH    = 2;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_CLK_DIV   = 5;
   localparam int DEF_SYNC_IDLE = 2;
   localparam int DEF_REFRESH   = 0;

   // Channel index width; a single channel still gets a 1-bit index port.
   function automatic int ch_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pending_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pending_arbiter
//  Purpose  : Combinational round-robin picker. Returns the first set bit of
//             i_pending strictly after i_last, wrapping around. Presenting an
//             all-ones vector yields the plain "next channel" sequence.
//  Ports    : i_pending  NUM_CH  request vector
//             i_last     CH_W    last-served channel index
//             o_grant    CH_W    selected channel index
//             o_any      1       a request was found
//  Revision : 1.0  initial release
// ============================================================================
module rr_pending_arbiter
   import dac_pkg::*;
#(
   parameter  int NUM_CH = DEF_NUM_CH,
   localparam int CH_W   = ch_idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_pending,
   input  logic [CH_W-1:0]   i_last,
   output logic [CH_W-1:0]   o_grant,
   output logic              o_any
);

   // Offset i=1 is the channel right after i_last, i=NUM_CH is i_last itself,
   // so the last-served channel has the lowest priority.
   always_comb begin
      o_grant = '0;
      o_any   = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         for (int j = 0; j < NUM_CH; j++) begin
            if (!o_any && i_pending[j] && (j == ((int'(i_last) + i) % NUM_CH))) begin
               o_any   = 1'b1;
               o_grant = CH_W'(j);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/multi_dac_driver.sv
`default_nettype none
// ============================================================================
//  Module   : multi_dac_driver
//  Purpose  : Multi-channel serial DAC driver. Per-channel sample writes land
//             in shadow registers and set a pending flag; a round-robin
//             arbiter picks the next channel and the FSM shifts the shadow
//             word MSB-first on a shared sclk/dout bus with a per-channel
//             active-low sync line. Optional continuous refresh.
//  Ports    : i_clk         1       block clock
//             i_reset       1       synchronous reset, active low
//             i_load_valid  1       write request
//             o_load_ready  1       write accepted when high with valid
//             i_load_ch     CH_W    target channel
//             i_load_data   DATA_W  sample word
//             o_load_err    1       pulse: handshake with out-of-range channel
//             o_sclk        1       serial clock, idles high
//             o_sync        NUM_CH  per-channel frame select, active low
//             o_dout        1       serial data
//             o_busy        1       FSM not idle
//             o_done        1       pulse at end of frame hold gap
//             o_done_ch     CH_W    channel of the completed frame
//  Revision : 1.0  initial release
// ============================================================================
module multi_dac_driver
   import dac_pkg::*;
#(
   parameter  int NUM_CH    = DEF_NUM_CH,
   parameter  int DATA_W    = DEF_DATA_W,
   parameter  int CLK_DIV   = DEF_CLK_DIV,
   parameter  int SYNC_IDLE = DEF_SYNC_IDLE,
   parameter  int REFRESH   = DEF_REFRESH,
   localparam int CH_W      = ch_idx_w(NUM_CH)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load_valid,
   output logic              o_load_ready,
   input  logic [CH_W-1:0]   i_load_ch,
   input  logic [DATA_W-1:0] i_load_data,
   output logic              o_load_err,
   output logic              o_sclk,
   output logic [NUM_CH-1:0] o_sync,
   output logic              o_dout,
   output logic              o_busy,
   output logic              o_done,
   output logic [CH_W-1:0]   o_done_ch
);

   localparam int c_DIV_W  = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);
   localparam int c_BIT_W  = $clog2(DATA_W + 1);
   localparam int c_HOLD_W = (SYNC_IDLE <= 1) ? 1 : $clog2(SYNC_IDLE);
   localparam logic [CH_W-1:0] c_LAST_CH = CH_W'(NUM_CH - 1);

   dac_state_e          r_state;
   logic [c_DIV_W-1:0]  r_div;
   logic [c_BIT_W-1:0]  r_bitcnt;
   logic [c_HOLD_W-1:0] r_hold;
   logic [DATA_W-1:0]   r_shift;
   logic [DATA_W-1:0]   r_shadow [NUM_CH];
   logic [NUM_CH-1:0]   r_pending;
   logic [NUM_CH-1:0]   r_sync;
   logic [CH_W-1:0]     r_last;
   logic [CH_W-1:0]     r_cur;
   logic [CH_W-1:0]     r_done_ch;
   logic                r_sclk;
   logic                r_dout;
   logic                r_done;
   logic                r_err;

   logic                w_tick;
   logic                w_ch_ok;
   logic                w_wr_ok;
   logic                w_wr_bad;
   logic [CH_W-1:0]     w_pend_grant;
   logic                w_pend_any;
   logic [CH_W-1:0]     w_rr_grant;
   logic                w_rr_any;
   logic [CH_W-1:0]     w_sel_ch;
   logic                w_sel_any;
   logic                w_next_bit;

   assign o_load_ready = i_reset;
   assign w_tick       = (r_div == c_DIV_W'(CLK_DIV - 1));
   assign w_ch_ok      = (int'(i_load_ch) < NUM_CH);
   assign w_wr_ok      = i_load_valid && o_load_ready && w_ch_ok;
   assign w_wr_bad     = i_load_valid && o_load_ready && !w_ch_ok;

   // Pending requests always take priority; refresh only fills idle slots.
   // One register serves as both last-served channel and refresh pointer,
   // since every frame start updates them to the same value.
   rr_pending_arbiter #(.NUM_CH(NUM_CH)) u_arb_pend (
      .i_pending (r_pending),
      .i_last    (r_last),
      .o_grant   (w_pend_grant),
      .o_any     (w_pend_any)
   );

   rr_pending_arbiter #(.NUM_CH(NUM_CH)) u_arb_rr (
      .i_pending ({NUM_CH{1'b1}}),
      .i_last    (r_last),
      .o_grant   (w_rr_grant),
      .o_any     (w_rr_any)
   );

   assign w_sel_any = w_pend_any || ((REFRESH != 0) && w_rr_any);
   assign w_sel_ch  = w_pend_any ? w_pend_grant : w_rr_grant;

   generate
      if (DATA_W > 1) begin : g_next_bit
         assign w_next_bit = r_shift[DATA_W-2];
      end else begin : g_next_bit_w1
         assign w_next_bit = 1'b0;
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state   <= IDLE;
         r_div     <= '0;
         r_bitcnt  <= '0;
         r_hold    <= '0;
         r_shift   <= '0;
         r_pending <= '0;
         r_sync    <= '1;
         r_last    <= c_LAST_CH;
         r_cur     <= '0;
         r_done_ch <= '0;
         r_sclk    <= 1'b1;
         r_dout    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            r_shadow[k] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         r_err  <= w_wr_bad;

         case (r_state)
            IDLE: begin
               r_div <= '0;
               if (w_sel_any) begin
                  r_shift             <= r_shadow[w_sel_ch];
                  r_dout              <= r_shadow[w_sel_ch][DATA_W-1];
                  r_pending[w_sel_ch] <= 1'b0;
                  r_cur               <= w_sel_ch;
                  r_last              <= w_sel_ch;
                  r_bitcnt            <= '0;
                  for (int k = 0; k < NUM_CH; k++) begin
                     r_sync[k] <= (CH_W'(k) != w_sel_ch);
                  end
                  r_state <= SETUP;
               end
            end

            SETUP: begin
               if (w_tick) begin
                  r_div   <= '0;
                  r_state <= SHIFT;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end

            SHIFT: begin
               if (w_tick) begin
                  r_div  <= '0;
                  r_sclk <= ~r_sclk;
                  if (r_sclk) begin
                     // Falling edge: the DAC latches the bit on dout.
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end else if (r_bitcnt < c_BIT_W'(DATA_W)) begin
                     r_shift <= r_shift << 1;
                     r_dout  <= w_next_bit;
                  end else begin
                     r_sync  <= '1;
                     r_dout  <= 1'b0;
                     r_hold  <= '0;
                     r_state <= HOLD;
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end

            HOLD: begin
               if (w_tick) begin
                  r_div <= '0;
                  if (r_hold == c_HOLD_W'(SYNC_IDLE - 1)) begin
                     r_done    <= 1'b1;
                     r_done_ch <= r_cur;
                     r_state   <= IDLE;
                  end else begin
                     r_hold <= r_hold + 1'b1;
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end

            default: r_state <= IDLE;
         endcase

         // Placed after the FSM so a write coinciding with selection of the
         // same channel keeps it pending; the frame already took the old word.
         if (w_wr_ok) begin
            r_shadow[i_load_ch]  <= i_load_data;
            r_pending[i_load_ch] <= 1'b1;
         end
      end
   end

   assign o_load_err = r_err;
   assign o_sclk     = r_sclk;
   assign o_sync     = r_sync;
   assign o_dout     = r_dout;
   assign o_busy     = (r_state != IDLE);
   assign o_done     = r_done;
   assign o_done_ch  = r_done_ch;

endmodule
`default_nettype wire

// File: tb/tb_multi_dac_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_dac_driver
//  Purpose  : Self-checking bench for multi_dac_driver. Main instance uses
//             NUM_CH=4, DATA_W=16, CLK_DIV=2, SYNC_IDLE=2; a 3-channel
//             instance exercises out-of-range channel writes; a REFRESH=1
//             instance exercises continuous refresh.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_dac_driver;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---- main instance ----
   logic        va;
   logic [1:0]  cha;
   logic [15:0] da;
   logic        ra, erra, sclka, douta, busya, donea;
   logic [3:0]  synca;
   logic [1:0]  donecha;

   multi_dac_driver #(.NUM_CH(4), .DATA_W(16), .CLK_DIV(2), .SYNC_IDLE(2), .REFRESH(0)) u_dut_a (
      .i_clk(clk), .i_reset(rst), .i_load_valid(va), .o_load_ready(ra), .i_load_ch(cha),
      .i_load_data(da), .o_load_err(erra), .o_sclk(sclka), .o_sync(synca), .o_dout(douta),
      .o_busy(busya), .o_done(donea), .o_done_ch(donecha)
   );

   // ---- 3-channel instance (channel index 3 is out of range) ----
   logic        vb;
   logic [1:0]  chb;
   logic [7:0]  db;
   logic        rb, errb, sclkb, doutb, busyb, doneb;
   logic [2:0]  syncb;
   logic [1:0]  donechb;

   multi_dac_driver #(.NUM_CH(3), .DATA_W(8), .CLK_DIV(1), .SYNC_IDLE(1), .REFRESH(0)) u_dut_b (
      .i_clk(clk), .i_reset(rst), .i_load_valid(vb), .o_load_ready(rb), .i_load_ch(chb),
      .i_load_data(db), .o_load_err(errb), .o_sclk(sclkb), .o_sync(syncb), .o_dout(doutb),
      .o_busy(busyb), .o_done(doneb), .o_done_ch(donechb)
   );

   // ---- refresh instance ----
   logic        vr;
   logic [1:0]  chr;
   logic [15:0] dr;
   logic        rr, errr, sclkr, doutr, busyr, doner;
   logic [3:0]  syncr;
   logic [1:0]  donechr;

   multi_dac_driver #(.NUM_CH(4), .DATA_W(16), .CLK_DIV(2), .SYNC_IDLE(2), .REFRESH(1)) u_dut_r (
      .i_clk(clk), .i_reset(rst), .i_load_valid(vr), .o_load_ready(rr), .i_load_ch(chr),
      .i_load_data(dr), .o_load_err(errr), .o_sclk(sclkr), .o_sync(syncr), .o_dout(doutr),
      .o_busy(busyr), .o_done(doner), .o_done_ch(donechr)
   );

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int          ch;
      logic [15:0] data;
   } exp_t;

   typedef struct {
      int          ch;
      logic [15:0] data;
      int          len;
      int          nfall;
      int          gap;
      int          multi;
   } frame_t;

   exp_t   exp_q[$];
   frame_t obs_q[$];

   // Frame monitor for the main instance: captures bits at sclk falling edges.
   initial begin : mon_a
      bit     m_in;
      frame_t m_cur;
      logic   m_prev;
      int     m_gap;
      m_in = 0; m_gap = 0; m_prev = 1'b1;
      m_cur = '{ch: -1, data: 16'h0, len: 0, nfall: 0, gap: 0, multi: 0};
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            m_in  = 0;
            m_gap = 0;
         end else if (synca !== 4'hF) begin
            if (!m_in) begin
               m_in = 1;
               m_cur.ch = -1;
               for (int k = 0; k < 4; k++) if (synca[k] === 1'b0) m_cur.ch = k;
               m_cur.data = 16'h0; m_cur.len = 0; m_cur.nfall = 0;
               m_cur.gap = m_gap; m_cur.multi = 0; m_prev = 1'b1;
            end
            if ($countones(~synca) != 1) m_cur.multi = 1;
            m_cur.len++;
            if (m_prev && !sclka) begin
               m_cur.data = {m_cur.data[14:0], douta};
               m_cur.nfall++;
            end
            m_prev = sclka;
         end else begin
            if (m_in) begin
               obs_q.push_back(m_cur);
               m_in  = 0;
               m_gap = 0;
            end
            m_gap++;
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- helpers (stimulus / waiting only) ----------------
   task automatic wr_a(input logic [1:0] ch, input logic [15:0] d);
      va = 1'b1; cha = ch; da = d;
      @(negedge clk);
      va = 1'b0;
   endtask

   task automatic wait_obs(input int n, output bit ok);
      int t = 0;
      while (obs_q.size() < n && t < 3000) begin @(negedge clk); t++; end
      ok = (obs_q.size() >= n);
   endtask

   task automatic wait_idle_a(output bit ok);
      int t = 0;
      while (busya !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
      ok = (busya === 1'b0);
   endtask

   task automatic grab_r(output int ch, output logic [15:0] d, output bit ok);
      int   t = 0;
      logic p = 1'b1;
      ch = -1; d = 16'h0; ok = 0;
      while (syncr === 4'hF && t < 1000) begin @(negedge clk); t++; end
      if (syncr === 4'hF) return;
      for (int k = 0; k < 4; k++) if (syncr[k] === 1'b0) ch = k;
      while (syncr !== 4'hF && t < 1000) begin
         if (p && !sclkr) d = {d[14:0], doutr};
         p = sclkr;
         @(negedge clk); t++;
      end
      ok = (syncr === 4'hF);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      va = 0; cha = 0; da = 0; vb = 0; chb = 0; db = 0; vr = 0; chr = 0; dr = 0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({sclka, synca, douta, busya, donea, erra, donecha, ra} !== {1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_a: got %b want %b", {sclka, synca, douta, busya, donea, erra, donecha, ra},
                  {1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0});
      end
      n_vec++;
      if ({syncb, sclkb, syncr, sclkr, rr} !== {3'b111, 1'b1, 4'hF, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_br: got %b want %b", {syncb, sclkb, syncr, sclkr, rr}, {3'b111, 1'b1, 4'hF, 1'b1, 1'b0});
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (ra !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", ra); end
   endtask

   task automatic test_single();
      bit ok;
      int t, d;
      frame_t f;
      exp_t e;
      wait_idle_a(ok);
      exp_q.push_back('{ch: 2, data: 16'hA5C3});
      wr_a(2'd2, 16'hA5C3);
      n_vec++;
      if (synca !== 4'hF) begin n_bad++; $display("FAIL single_lat1: sync got %h want f", synca); end
      @(negedge clk);
      n_vec++;
      if ({synca, busya} !== {4'b1011, 1'b1}) begin
         n_bad++; $display("FAIL single_lat2: sync/busy got %b want 10111", {synca, busya});
      end
      t = 0;
      while (synca !== 4'hF && t < 200) begin @(negedge clk); t++; end
      d = 0;
      while (donea !== 1'b1 && d < 40) begin @(negedge clk); d++; end
      n_vec++;
      if (d != 4 || donecha !== 2'd2 || busya !== 1'b0) begin
         n_bad++; $display("FAIL single_done: delay %0d ch %0d busy %b want 4 2 0", d, donecha, busya);
      end
      @(negedge clk);
      n_vec++;
      if (donea !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse: got %b want 0", donea); end
      wait_obs(1, ok);
      n_vec++;
      if (!ok) begin
         n_bad++; $display("FAIL single_frame: got %0d frames want 1", obs_q.size());
      end else begin
         f = obs_q.pop_front(); e = exp_q.pop_front();
         n_vec++;
         if (f.ch != e.ch || f.data !== e.data || f.len != 66 || f.nfall != 16 || f.multi != 0) begin
            n_bad++;
            $display("FAIL single_data: got ch%0d %h len%0d fall%0d multi%0d want ch%0d %h len66 fall16 multi0",
                     f.ch, f.data, f.len, f.nfall, f.multi, e.ch, e.data);
         end
      end
   endtask

   task automatic test_sequence();
      bit ok;
      frame_t f;
      exp_t e;
      wait_idle_a(ok);
      exp_q.push_back('{ch: 0, data: 16'h0001});
      exp_q.push_back('{ch: 1, data: 16'h0003});
      exp_q.push_back('{ch: 3, data: 16'h0002});
      wr_a(2'd0, 16'h0001);
      wr_a(2'd3, 16'h0002);
      wr_a(2'd1, 16'h0003);
      wait_obs(3, ok);
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL seq_count: got %0d frames want 3", obs_q.size()); end
      for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
         f = obs_q.pop_front(); e = exp_q.pop_front();
         n_vec++;
         if (f.ch != e.ch || f.data !== e.data || f.len != 66 || f.nfall != 16 || f.multi != 0) begin
            n_bad++;
            $display("FAIL seq_frame%0d: got ch%0d %h len%0d fall%0d want ch%0d %h len66 fall16",
                     i, f.ch, f.data, f.len, f.nfall, e.ch, e.data);
         end
         if (i > 0) begin
            n_vec++;
            if (f.gap != 5) begin n_bad++; $display("FAIL seq_gap%0d: got %0d want 5", i, f.gap); end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_overwrite();
      bit ok;
      frame_t f;
      exp_t e;
      wait_idle_a(ok);
      // second write lands on the same edge that selects channel 1
      exp_q.push_back('{ch: 1, data: 16'hAAAA});
      exp_q.push_back('{ch: 1, data: 16'h1111});
      wr_a(2'd1, 16'hAAAA);
      wr_a(2'd1, 16'h1111);
      wait_obs(2, ok);
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL ovw_count: got %0d frames want 2", obs_q.size()); end
      for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
         f = obs_q.pop_front(); e = exp_q.pop_front();
         n_vec++;
         if (f.ch != e.ch || f.data !== e.data) begin
            n_bad++; $display("FAIL ovw_frame%0d: got ch%0d %h want ch%0d %h", i, f.ch, f.data, e.ch, e.data);
         end
      end
      exp_q.delete();
      repeat (200) @(negedge clk);
      n_vec++;
      if (busya !== 1'b0 || synca !== 4'hF || obs_q.size() != 0) begin
         n_bad++; $display("FAIL ovw_pending_clear: busy %b sync %h extra %0d want 0 f 0", busya, synca, obs_q.size());
      end
   endtask

   task automatic test_load_err();
      vb = 1'b1; chb = 2'd3; db = 8'h77;
      @(negedge clk);
      vb = 1'b0;
      n_vec++;
      if (errb !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got %b want 1", errb); end
      @(negedge clk);
      n_vec++;
      if (errb !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got %b want 0", errb); end
      repeat (20) @(negedge clk);
      n_vec++;
      if (busyb !== 1'b0 || syncb !== 3'b111) begin
         n_bad++; $display("FAIL err_no_frame: busy %b sync %b want 0 111", busyb, syncb);
      end
      vb = 1'b1; chb = 2'd2; db = 8'hC6;
      @(negedge clk);
      vb = 1'b0;
      @(negedge clk);
      n_vec++;
      if (syncb !== 3'b011 || errb !== 1'b0) begin
         n_bad++; $display("FAIL err_valid_write: sync %b err %b want 011 0", syncb, errb);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int t, nf;
      logic p;
      wait_idle_a(ok);
      wr_a(2'd3, 16'hF0F0);
      t = 0; nf = 0; p = 1'b1;
      while (nf < 7 && t < 300) begin
         @(negedge clk); t++;
         if (synca !== 4'hF && p && !sclka) nf++;
         p = sclka;
      end
      n_vec++;
      if (nf != 7 || synca !== 4'b0111) begin
         n_bad++; $display("FAIL rstmid_reach: falls %0d sync %b want 7 0111", nf, synca);
      end
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({sclka, synca, douta, busya, donea} !== {1'b1, 4'hF, 1'b0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL rstmid_abort: got %b want 11111000", {sclka, synca, douta, busya, donea});
      end
      rst = 1'b1;
      repeat (100) @(negedge clk);
      n_vec++;
      if (busya !== 1'b0 || synca !== 4'hF || obs_q.size() != 0) begin
         n_bad++; $display("FAIL rstmid_no_restart: busy %b sync %h frames %0d want 0 f 0", busya, synca, obs_q.size());
      end
   endtask

   task automatic test_refresh();
      int ch;
      logic [15:0] d;
      bit ok;
      exp_t e;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back('{ch: i, data: 16'h0000});
      for (int i = 0; i < 4; i++) begin
         grab_r(ch, d, ok);
         e = exp_q.pop_front();
         n_vec++;
         if (!ok || ch != e.ch || d !== e.data) begin
            n_bad++; $display("FAIL refresh_rr%0d: ok %0d got ch%0d %h want ch%0d %h", i, ok, ch, d, e.ch, e.data);
         end
      end
      // written during the hold gap after ch3; pending beats refresh order
      vr = 1'b1; chr = 2'd2; dr = 16'hFFFF;
      @(negedge clk);
      vr = 1'b0;
      exp_q.push_back('{ch: 2, data: 16'hFFFF});
      exp_q.push_back('{ch: 3, data: 16'h0000});
      exp_q.push_back('{ch: 0, data: 16'h0000});
      for (int i = 0; i < 3; i++) begin
         grab_r(ch, d, ok);
         e = exp_q.pop_front();
         n_vec++;
         if (!ok || ch != e.ch || d !== e.data) begin
            n_bad++; $display("FAIL refresh_wr%0d: ok %0d got ch%0d %h want ch%0d %h", i, ok, ch, d, e.ch, e.data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_sequence();
      test_overwrite();
      test_load_err();
      test_reset_mid();
      test_refresh();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
